// File: rtl/uart_reg_bridge_if.sv
// rtl/uart_reg_bridge_if.sv - byte-stream and register-bus signals of the UART register bridge
interface uart_reg_bridge_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [7:0]        tx_data;
   logic              reg_wr_en;
   logic              reg_rd_en;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata;
   logic              reg_rd_valid;
   logic              busy;

   modport master (
      input  rx_valid, rx_data, tx_ready, reg_rdata, reg_rd_valid,
      output rx_ready, tx_valid, tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, busy
   );

   modport slave (
      output rx_valid, rx_data, tx_ready, reg_rdata, reg_rd_valid,
      input  rx_ready, tx_valid, tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, busy
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - decodes UART command frames into register writes/reads and returns replies
module uart_reg_bridge #(
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16
) (
   input logic               clk,
   input logic               rst,
   uart_reg_bridge_if.master bus
);
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_WR    = 8'h57;
   localparam logic [7:0] CMD_RD    = 8'h52;
   localparam logic [7:0] REPLY_ACK = 8'h4B;
   localparam logic [7:0] REPLY_BAD = 8'h3F;
   localparam logic [7:0] REPLY_TMO = 8'h21;

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DHI, GET_DLO, DO_WR, DO_RD, RD_WAIT, SEND_HI, SEND_LO, SEND_1
   } state_t;

   state_t             state_q, state_d;
   logic               is_wr_q, is_wr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [7:0]         rd_lo_q, rd_lo_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               rx_ready_q, rx_ready_d;
   logic               wr_en_q, wr_en_d;
   logic               rd_en_q, rd_en_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic rx_fire;
   logic tx_fire;
   logic timed_out;
   logic counting;

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_lo_d   = rd_lo_q;
      tx_data_d = tx_data_q;
      rx_fire   = bus.rx_valid && rx_ready_q;
      tx_fire   = tx_valid_q && bus.tx_ready;
      timed_out = (cnt_q == CNT_LAST);

      case (state_q)
         IDLE: begin
            if (rx_fire) begin
               if (bus.rx_data == CMD_WR) begin
                  is_wr_d = 1'b1;
                  state_d = GET_ADDR;
               end else if (bus.rx_data == CMD_RD) begin
                  is_wr_d = 1'b0;
                  state_d = GET_ADDR;
               end else begin
                  tx_data_d = REPLY_BAD;
                  state_d   = SEND_1;
               end
            end
         end
         // Timeout takes priority: a byte landing on the timeout edge is dropped.
         GET_ADDR: begin
            if (timed_out) begin
               state_d = IDLE;
            end else if (rx_fire) begin
               addr_d  = bus.rx_data;
               state_d = is_wr_q ? GET_DHI : DO_RD;
            end
         end
         GET_DHI: begin
            if (timed_out) begin
               state_d = IDLE;
            end else if (rx_fire) begin
               wdata_d[15:8] = bus.rx_data;
               state_d       = GET_DLO;
            end
         end
         GET_DLO: begin
            if (timed_out) begin
               state_d = IDLE;
            end else if (rx_fire) begin
               wdata_d[7:0] = bus.rx_data;
               state_d      = DO_WR;
            end
         end
         DO_WR: begin
            tx_data_d = REPLY_ACK;
            state_d   = SEND_1;
         end
         DO_RD: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.reg_rd_valid) begin
               tx_data_d = bus.reg_rdata[15:8];
               rd_lo_d   = bus.reg_rdata[7:0];
               state_d   = SEND_HI;
            end else if (timed_out) begin
               tx_data_d = REPLY_TMO;
               state_d   = SEND_1;
            end
         end
         SEND_HI: begin
            if (tx_fire) begin
               tx_data_d = rd_lo_q;
               state_d   = SEND_LO;
            end
         end
         SEND_LO, SEND_1: begin
            if (tx_fire) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Any state change clears the counter, which covers accepted bytes and RD_WAIT entry.
      counting = (state_d == state_q) &&
                 (state_q == GET_ADDR || state_q == GET_DHI ||
                  state_q == GET_DLO  || state_q == RD_WAIT);
      if (!counting) begin
         cnt_d = '0;
      end else if (timed_out) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      rx_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) ||
                   (state_d == GET_DHI) || (state_d == GET_DLO);
      tx_valid_d = (state_d == SEND_HI) || (state_d == SEND_LO) || (state_d == SEND_1);
      wr_en_d    = (state_d == DO_WR);
      rd_en_d    = (state_d == DO_RD);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_lo_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_lo_q    <= rd_lo_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rx_ready_q <= rx_ready_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.reg_wr_en = wr_en_q;
   assign bus.reg_rd_en = rd_en_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - self-checking bench for uart_reg_bridge
module tb_uart_reg_bridge;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_reg_bridge_if bif ();

   uart_reg_bridge #(.TIMEOUT_CYCLES(TMO), .ADDR_W(8), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      logic [7:0]  b [4];
      int          nb;
      logic [7:0]  r [2];
      int          nr;
      bit          wr;
      bit          rd;
      logic [7:0]  a;
      logic [15:0] d;
   } vec_t;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] dev_regs   [256];
   logic [15:0] model_regs [256];
   logic [7:0]  tx_log [$];
   logic [23:0] wr_log [$];
   logic [7:0]  rd_log [$];
   logic [7:0]  q_cmd  [$];
   logic [7:0]  q_tx   [$];
   logic [23:0] q_wr   [$];
   logic [7:0]  q_rd   [$];
   bit          rd_auto    = 1'b1;
   int          rd_lat     = 3;
   int          tx_mode    = 1;
   bit          man_valid  = 1'b0;
   logic [15:0] man_rdata  = 16'h0;
   bit          both_err   = 1'b0;
   bit          stable_err = 1'b0;

   // Register device, UART transmit side and transfer monitor, all updated #2 after each edge.
   initial begin
      int         cd;
      logic [7:0] rd_addr;
      logic       pv, pr;
      logic [7:0] pd;
      cd = 0; rd_addr = 0; pv = 0; pr = 0; pd = 0;
      for (int i = 0; i < 256; i++) dev_regs[i] = 16'h0;
      dev_regs[8'h34]  = 16'hBEEF;
      bif.reg_rd_valid = 1'b0;
      bif.reg_rdata    = 16'h0;
      bif.tx_ready     = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (tx_mode == 2) bif.tx_ready = ($urandom_range(0, 3) != 0);
         else bif.tx_ready = (tx_mode == 1);
         if (bif.reg_wr_en && bif.reg_rd_en) both_err = 1'b1;
         if (rst && pv && !pr && bif.tx_valid && bif.tx_data !== pd) stable_err = 1'b1;
         pv = bif.tx_valid; pr = bif.tx_ready; pd = bif.tx_data;
         if (bif.tx_valid && bif.tx_ready) tx_log.push_back(bif.tx_data);
         if (bif.reg_wr_en) begin
            wr_log.push_back({bif.reg_addr, bif.reg_wdata});
            dev_regs[bif.reg_addr] = bif.reg_wdata;
         end
         if (bif.reg_rd_en) rd_log.push_back(bif.reg_addr);
         if (rd_auto) begin
            bif.reg_rd_valid = 1'b0;
            bif.reg_rdata    = 16'($urandom);
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  bif.reg_rd_valid = 1'b1;
                  bif.reg_rdata    = dev_regs[rd_addr];
               end
            end
            if (bif.reg_rd_en) begin
               cd      = rd_lat;
               rd_addr = bif.reg_addr;
            end
         end else begin
            bif.reg_rd_valid = man_valid;
            bif.reg_rdata    = man_rdata;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      tx_log.delete(); wr_log.delete(); rd_log.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bif.rx_valid = 1'b1;
      bif.rx_data  = b;
      while (!bif.rx_ready && n < 200) begin
         tick();
         n++;
      end
      check("rx_accept", bif.rx_ready, 1);
      if (bif.rx_ready) tick();
      bif.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((bif.busy || bif.tx_valid) && n < budget) begin
         tick();
         n++;
      end
      check("idle_reached", bif.busy, 0);
   endtask

   // Sends q_cmd and compares everything observed against q_tx / q_wr / q_rd.
   task automatic run_frame(input int gap_max);
      clear_logs();
      foreach (q_cmd[i]) begin
         repeat ($urandom_range(0, gap_max)) tick();
         send_byte(q_cmd[i]);
      end
      wait_idle(600);
      check("tx_count", tx_log.size(), q_tx.size());
      foreach (q_tx[i]) if (i < tx_log.size()) check("tx_byte", tx_log[i], q_tx[i]);
      check("wr_count", wr_log.size(), q_wr.size());
      foreach (q_wr[i]) if (i < wr_log.size()) check("wr_addr_data", wr_log[i], q_wr[i]);
      check("rd_count", rd_log.size(), q_rd.size());
      foreach (q_rd[i]) if (i < rd_log.size()) check("rd_addr", rd_log[i], q_rd[i]);
   endtask

   task automatic clear_q();
      q_cmd.delete(); q_tx.delete(); q_wr.delete(); q_rd.delete();
   endtask

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int nb,
                               input logic [7:0] r0, r1, input int nr,
                               input bit wr, rd, input logic [7:0] a, input logic [15:0] d);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.nb = nb;
      v.r[0] = r0; v.r[1] = r1; v.nr = nr;
      v.wr = wr; v.rd = rd; v.a = a; v.d = d;
      return v;
   endfunction

   initial begin
      vec_t        tbl [12];
      logic [7:0]  ra, ub;
      logic [15:0] rd16;
      bit          bp_ok;
      int          n;

      tbl[0]  = mk(8'h57, 8'h12, 8'hAB, 8'hCD, 4, 8'h4B, 8'h00, 1, 1, 0, 8'h12, 16'hABCD);
      tbl[1]  = mk(8'h52, 8'h12, 8'h00, 8'h00, 2, 8'hAB, 8'hCD, 2, 0, 1, 8'h12, 16'h0);
      tbl[2]  = mk(8'h52, 8'h34, 8'h00, 8'h00, 2, 8'hBE, 8'hEF, 2, 0, 1, 8'h34, 16'h0);
      tbl[3]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h3F, 8'h00, 1, 0, 0, 8'h00, 16'h0);
      tbl[4]  = mk(8'h77, 8'h00, 8'h00, 8'h00, 1, 8'h3F, 8'h00, 1, 0, 0, 8'h00, 16'h0);
      tbl[5]  = mk(8'hFF, 8'h00, 8'h00, 8'h00, 1, 8'h3F, 8'h00, 1, 0, 0, 8'h00, 16'h0);
      tbl[6]  = mk(8'h57, 8'h00, 8'h00, 8'h01, 4, 8'h4B, 8'h00, 1, 1, 0, 8'h00, 16'h0001);
      tbl[7]  = mk(8'h52, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h01, 2, 0, 1, 8'h00, 16'h0);
      tbl[8]  = mk(8'h57, 8'hFF, 8'hFF, 8'hFF, 4, 8'h4B, 8'h00, 1, 1, 0, 8'hFF, 16'hFFFF);
      tbl[9]  = mk(8'h52, 8'hFF, 8'h00, 8'h00, 2, 8'hFF, 8'hFF, 2, 0, 1, 8'hFF, 16'h0);
      tbl[10] = mk(8'h51, 8'h00, 8'h00, 8'h00, 1, 8'h3F, 8'h00, 1, 0, 0, 8'h00, 16'h0);
      tbl[11] = mk(8'h52, 8'h56, 8'h00, 8'h00, 2, 8'h00, 8'h00, 2, 0, 1, 8'h56, 16'h0);

      for (int i = 0; i < 256; i++) model_regs[i] = 16'h0;
      model_regs[8'h34] = 16'hBEEF;

      // Reset state
      rst = 1'b0; bif.rx_valid = 1'b0; bif.rx_data = 8'h0;
      repeat (3) tick();
      check("rst_rx_ready", bif.rx_ready, 0);
      check("rst_tx_valid", bif.tx_valid, 0);
      check("rst_tx_data", bif.tx_data, 0);
      check("rst_busy", bif.busy, 0);
      check("rst_strobes", {bif.reg_wr_en, bif.reg_rd_en}, 0);
      check("rst_addr_wdata", {bif.reg_addr, bif.reg_wdata}, 0);
      rst = 1'b1;
      tick();
      check("rx_ready_after_reset", bif.rx_ready, 1);

      // Write with exact strobe and reply latency
      clear_logs();
      send_byte(8'h57); send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD);
      check("wr_pulse", bif.reg_wr_en, 1);
      check("wr_addr", bif.reg_addr, 8'h12);
      check("wr_data", bif.reg_wdata, 16'hABCD);
      check("wr_no_tx_yet", bif.tx_valid, 0);
      tick();
      check("wr_pulse_end", bif.reg_wr_en, 0);
      check("wr_ack_valid", bif.tx_valid, 1);
      check("wr_ack_data", bif.tx_data, 8'h4B);
      check("wr_addr_held", {bif.reg_addr, bif.reg_wdata}, 24'h12ABCD);
      tick();
      check("wr_done_busy", bif.busy, 0);
      check("wr_log_count", wr_log.size(), 1);
      model_regs[8'h12] = 16'hABCD;

      // Read with rd_valid three cycles after the strobe
      rd_auto = 1'b0; man_valid = 1'b0; man_rdata = 16'h1111;
      clear_logs();
      send_byte(8'h52); send_byte(8'h34);
      check("rd_pulse", bif.reg_rd_en, 1);
      check("rd_addr", bif.reg_addr, 8'h34);
      tick();
      check("rd_pulse_end", bif.reg_rd_en, 0);
      repeat (2) tick();
      check("rd_wait_no_tx", bif.tx_valid, 0);
      man_valid = 1'b1; man_rdata = 16'hBEEF;
      tick();
      man_valid = 1'b0; man_rdata = 16'h2222;
      check("rd_hi_valid", bif.tx_valid, 1);
      check("rd_hi_data", bif.tx_data, 8'hBE);
      tick();
      check("rd_lo_valid", bif.tx_valid, 1);
      check("rd_lo_data", bif.tx_data, 8'hEF);
      tick();
      check("rd_done", {bif.tx_valid, bif.busy}, 0);
      check("rd_tx_count", tx_log.size(), 2);
      rd_auto = 1'b1;

      // Unknown command under transmit back-pressure
      tx_mode = 0;
      clear_logs();
      send_byte(8'h00);
      bp_ok = 1'b1;
      repeat (20) begin
         if (!(bif.tx_valid && bif.tx_data == 8'h3F && !bif.rx_ready)) bp_ok = 1'b0;
         tick();
      end
      check("bp_hold", bp_ok, 1);
      tx_mode = 1;
      tick();
      check("bp_release", {bif.tx_valid, bif.busy}, 0);
      check("bp_tx_count", tx_log.size(), 1);
      if (tx_log.size() > 0) check("bp_tx_byte", tx_log[0], 8'h3F);
      tick();
      check("bp_rx_ready", bif.rx_ready, 1);

      // Inter-byte timeout mid-frame, then a normal read
      clear_logs();
      send_byte(8'h57); send_byte(8'h12);
      repeat (TMO - 1) tick();
      check("tmo_not_early", bif.busy, 1);
      tick();
      check("tmo_idle", bif.busy, 0);
      check("tmo_no_activity", tx_log.size() + wr_log.size() + rd_log.size(), 0);
      clear_q();
      q_cmd.push_back(8'h52); q_cmd.push_back(8'h12);
      q_tx.push_back(model_regs[8'h12][15:8]); q_tx.push_back(model_regs[8'h12][7:0]);
      q_rd.push_back(8'h12);
      run_frame(0);

      // Byte arriving on the timeout edge is discarded
      clear_logs();
      send_byte(8'h57);
      repeat (TMO - 1) tick();
      bif.rx_valid = 1'b1; bif.rx_data = 8'h52;
      tick();
      bif.rx_valid = 1'b0;
      check("tmo_edge_discard", bif.busy, 0);
      repeat (3) tick();
      check("tmo_edge_no_tx", tx_log.size(), 0);

      // Read data never returned
      rd_auto = 1'b0; man_valid = 1'b0;
      clear_q();
      q_cmd.push_back(8'h52); q_cmd.push_back(8'h40);
      q_tx.push_back(8'h21); q_rd.push_back(8'h40);
      run_frame(0);
      rd_auto = 1'b1;

      // Reset while the high read byte is stalled
      tx_mode = 0; rd_lat = 2;
      clear_logs();
      send_byte(8'h52); send_byte(8'h34);
      n = 0;
      while (!bif.tx_valid && n < 50) begin tick(); n++; end
      check("mid_hi_pending", {bif.tx_valid, bif.tx_data}, 9'h1BE);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid_rst_tx", {bif.tx_valid, bif.tx_data}, 0);
      check("mid_rst_busy_rdy", {bif.busy, bif.rx_ready}, 0);
      check("mid_rst_bus", {bif.reg_wr_en, bif.reg_rd_en, bif.reg_addr, bif.reg_wdata}, 0);
      tx_mode = 1;
      tick();
      clear_q();
      q_cmd.push_back(8'h57); q_cmd.push_back(8'h60); q_cmd.push_back(8'h12); q_cmd.push_back(8'h34);
      q_tx.push_back(8'h4B); q_wr.push_back(24'h601234);
      run_frame(0);
      check("mid_rst_no_stale_tx", tx_log.size(), 1);
      model_regs[8'h60] = 16'h1234;

      // Table of single frames
      rd_lat = 3;
      foreach (tbl[i]) begin
         clear_q();
         for (int j = 0; j < tbl[i].nb; j++) q_cmd.push_back(tbl[i].b[j]);
         for (int j = 0; j < tbl[i].nr; j++) q_tx.push_back(tbl[i].r[j]);
         if (tbl[i].wr) q_wr.push_back({tbl[i].a, tbl[i].d});
         if (tbl[i].rd) q_rd.push_back(tbl[i].a);
         run_frame(1);
         if (tbl[i].wr) model_regs[tbl[i].a] = tbl[i].d;
      end

      // Random frames against the register-map model
      tx_mode = 2;
      for (int k = 0; k < 60; k++) begin
         clear_q();
         rd_lat = $urandom_range(1, 6);
         ra = 8'h30 + 8'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0: begin
               rd16 = 16'($urandom);
               q_cmd.push_back(8'h57); q_cmd.push_back(ra);
               q_cmd.push_back(rd16[15:8]); q_cmd.push_back(rd16[7:0]);
               q_tx.push_back(8'h4B); q_wr.push_back({ra, rd16});
               model_regs[ra] = rd16;
            end
            1: begin
               q_cmd.push_back(8'h52); q_cmd.push_back(ra);
               q_tx.push_back(model_regs[ra][15:8]); q_tx.push_back(model_regs[ra][7:0]);
               q_rd.push_back(ra);
            end
            default: begin
               ub = 8'($urandom);
               while (ub == 8'h57 || ub == 8'h52) ub = 8'($urandom);
               q_cmd.push_back(ub);
               q_tx.push_back(8'h3F);
            end
         endcase
         run_frame(3);
      end
      tx_mode = 1;
      repeat (2) tick();

      check("strobe_exclusive", both_err, 0);
      check("tx_data_stable", stable_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
